// File: rtl/line_raster_ctrl_pkg.sv
// Shared definitions for the line rasterizer, its divider wrapper and the write arbiter.
package line_raster_ctrl_pkg;

    localparam int DEF_W  = 4;
    localparam int DEF_AW = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DIV  = 3'd1,
        ST_WAIT = 3'd2,
        ST_EMIT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/line_step_acc.sv
// Pixel stepper: x/y/address counters loaded on accept and advanced one pixel per step.
module line_step_acc
    import line_raster_ctrl_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int AW = DEF_AW
) (
    input  logic          c,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  logic [W-1:0]  x0,
    input  logic [W-1:0]  y0,
    input  logic [W-1:0]  x1,
    input  logic [AW-1:0] addr0,
    input  logic [W-1:0]  m,
    output logic [W-1:0]  x,
    output logic [W-1:0]  y,
    output logic [AW-1:0] addr,
    output logic          last
);

    logic [W-1:0] x_end;

    always_ff @(posedge c) begin
        if (rst) begin
            x     <= '0;
            y     <= '0;
            addr  <= '0;
            x_end <= '0;
        end else if (load) begin
            x     <= x0;
            y     <= y0;
            addr  <= addr0;
            x_end <= x1;
        end else if (step) begin
            x    <= x + W'(1);
            y    <= y + m;
            addr <= addr + AW'(1);
        end
    end

    // Equality, not <=, so a line ending at the top of the x range cannot wrap and loop.
    assign last = (x == x_end);

endmodule

// File: rtl/line_raster_ctrl.sv
// Line rasterizer sequencer: accepts a vertex pair, obtains the slope, then emits one write per x step.
//   state | meaning
//   IDLE  | waiting for a vertex pair, in_ready high
//   DIV   | div_start pulse with dy/dx presented
//   WAIT  | waiting for div_done, slope latched on it
//   EMIT  | presenting pixel writes, stepping on each accepted write
//   DONE  | one-cycle done pulse, pix_count final
module line_raster_ctrl
    import line_raster_ctrl_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int AW = DEF_AW
) (
    input  logic          c,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  v1x,
    input  logic [W-1:0]  v1y,
    input  logic [W-1:0]  v2x,
    input  logic [W-1:0]  v2y,
    input  logic [AW-1:0] base_addr,
    output logic          div_start,
    output logic [W-1:0]  div_num,
    output logic [W-1:0]  div_den,
    input  logic          div_done,
    input  logic [W-1:0]  div_q,
    output logic          wr_valid,
    input  logic          wr_ready,
    output logic [AW-1:0] wr_addr,
    output logic [W-1:0]  wr_x,
    output logic [W-1:0]  wr_y,
    output logic          busy,
    output logic          done,
    output logic [W:0]    pix_count
);

    state_t       state, state_nx;
    logic         accept, swap, step, last;
    logic [W-1:0] x0, y0, x1, y1, dx, dy, m;

    assign accept = in_valid & in_ready;
    assign swap   = (v2x < v1x);
    assign x0     = swap ? v2x : v1x;
    assign y0     = swap ? v2y : v1y;
    assign x1     = swap ? v1x : v2x;
    assign y1     = swap ? v1y : v2y;
    assign dx     = x1 - x0;
    assign dy     = y1 - y0;
    assign step   = (state == ST_EMIT) & wr_ready;

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        div_start = 1'b0;
        wr_valid  = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nx = (dx != '0) ? ST_DIV : ST_EMIT;
            end
            ST_DIV: begin
                div_start = 1'b1;
                state_nx  = ST_WAIT;
            end
            ST_WAIT: begin
                if (div_done) state_nx = ST_EMIT;
            end
            ST_EMIT: begin
                wr_valid = 1'b1;
                if (wr_ready) state_nx = last ? ST_DONE : ST_EMIT;
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge c) begin
        if (rst) begin
            state     <= ST_IDLE;
            m         <= '0;
            div_num   <= '0;
            div_den   <= '0;
            pix_count <= '0;
        end else begin
            state <= state_nx;
            // A vertical line never runs the divider, so the slope is cleared here.
            if (accept) begin
                div_num   <= dy;
                div_den   <= dx;
                m         <= '0;
                pix_count <= '0;
            end
            if ((state == ST_WAIT) && div_done) m <= div_q;
            if (step) pix_count <= pix_count + (W+1)'(1);
        end
    end

    line_step_acc #(.W(W), .AW(AW)) u_acc (
        .c     (c),
        .rst   (rst),
        .load  (accept),
        .step  (step),
        .x0    (x0),
        .y0    (y0),
        .x1    (x1),
        .addr0 (base_addr),
        .m     (m),
        .x     (wr_x),
        .y     (wr_y),
        .addr  (wr_addr),
        .last  (last)
    );

endmodule

// File: tb/tb_line_raster_ctrl.sv
// Bench for line_raster_ctrl: vector table, hand sequences and random lines against a pixel model.
module tb_line_raster_ctrl;

    logic       c = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] v1x, v1y, v2x, v2y;
    logic [7:0] base_addr;
    logic       div_start;
    logic [3:0] div_num, div_den;
    logic       div_done;
    logic [3:0] div_q;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_addr;
    logic [3:0] wr_x, wr_y;
    logic       busy;
    logic       done;
    logic [4:0] pix_count;

    int n_chk = 0;
    int n_err = 0;

    always #5 c = ~c;

    line_raster_ctrl #(.W(4), .AW(8)) dut (
        .c         (c),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .v1x       (v1x),
        .v1y       (v1y),
        .v2x       (v2x),
        .v2y       (v2y),
        .base_addr (base_addr),
        .div_start (div_start),
        .div_num   (div_num),
        .div_den   (div_den),
        .div_done  (div_done),
        .div_q     (div_q),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .busy      (busy),
        .done      (done),
        .pix_count (pix_count)
    );

    typedef struct {
        int v1x, v1y, v2x, v2y, base, q, lat, mode;
        int e_num, e_den, e_pix, e_xl, e_yl;
    } vec_t;

    vec_t tbl[8];

    task automatic tick();
        @(posedge c);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    // mode 0: always ready; 1: random ready plus bus noise while busy; 2: 3-cycle stall on pixel 1
    task automatic run_line(input int ax, input int ay, input int bx, input int by,
                            input int bs, input int q, input int lat, input int mode,
                            output int xl, output int yl, output int pc,
                            output int dn, output int dd);
        int x0, y0, x1, y1, dx, dy, m, idx, nst, cyc, done_at, stall;
        bit noise, held, exp_wv;
        logic [7:0] h_a;
        logic [3:0] h_x, h_y;
        if (bx < ax) begin
            x0 = bx; y0 = by; x1 = ax; y1 = ay;
        end else begin
            x0 = ax; y0 = ay; x1 = bx; y1 = by;
        end
        dx = x1 - x0;
        dy = (y1 - y0) & 15;
        m  = (dx == 0) ? 0 : q;
        noise = (mode == 1);
        idx = 0; nst = 0; cyc = 0; done_at = -1; stall = 0;
        held = 0; exp_wv = 0;
        xl = -1; yl = -1; dn = -1; dd = -1; pc = -1;
        h_a = '0; h_x = '0; h_y = '0;

        chk("in_ready_idle", int'(in_ready), 1);
        v1x = 4'(ax); v1y = 4'(ay); v2x = 4'(bx); v2y = 4'(by);
        base_addr = 8'(bs);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;

        while (1) begin
            if (cyc == 0) chk("first_cycle", (dx != 0) ? int'(div_start) : int'(wr_valid), 1);
            if (exp_wv) chk("wr_valid_after_div_done", int'(wr_valid), 1);
            if (held) chk("stall_hold", int'({wr_valid, wr_addr, wr_x, wr_y}),
                          int'({1'b1, h_a, h_x, h_y}));
            exp_wv = 0;
            held   = 0;
            if (div_start) begin
                nst++;
                dn = int'(div_num);
                dd = int'(div_den);
            end
            if (done || cyc >= 300) break;

            if (div_start) done_at = cyc + lat;
            div_done = (cyc == done_at);
            div_q    = div_done ? 4'(q) : 4'($urandom);
            exp_wv   = div_done;
            if (noise && !div_done && (div_start || wr_valid) && $urandom_range(0, 1) == 1)
                div_done = 1'b1;

            case (mode)
                0: wr_ready = 1'b1;
                1: wr_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (wr_valid && idx == 1 && stall < 3) begin
                        wr_ready = 1'b0;
                        stall++;
                    end else begin
                        wr_ready = 1'b1;
                    end
                end
            endcase

            if (wr_valid) begin
                if (wr_ready) begin
                    chk("wr_x", int'(wr_x), (x0 + idx) & 15);
                    chk("wr_y", int'(wr_y), (y0 + idx * m) & 15);
                    chk("wr_addr", int'(wr_addr), (bs + idx) & 255);
                    xl = int'(wr_x);
                    yl = int'(wr_y);
                    idx++;
                end else begin
                    held = 1;
                    h_a = wr_addr; h_x = wr_x; h_y = wr_y;
                end
            end

            if (noise) begin
                in_valid  = 1'($urandom_range(0, 1));
                v1x = 4'($urandom); v1y = 4'($urandom);
                v2x = 4'($urandom); v2y = 4'($urandom);
                base_addr = 8'($urandom);
            end
            tick();
            cyc++;
        end

        in_valid = 1'b0;
        div_done = 1'b0;
        chk("done_pulse", int'(done), 1);
        pc = int'(pix_count);
        chk("pix_count", pc, dx + 1);
        chk("n_writes", idx, dx + 1);
        chk("n_div_start", nst, (dx != 0) ? 1 : 0);
        if (dx != 0) begin
            chk("div_num", dn, dy);
            chk("div_den", dd, dx);
        end
        tick();
        chk("in_ready_after", int'(in_ready), 1);
        chk("wr_valid_after", int'(wr_valid), 0);
        chk("done_after", int'(done), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int xl, yl, pc, dn, dd;
        int ax, ay, bx, by;

        tbl[0] = '{1, 2, 4, 8, 'h10, 2, 1, 0, 6, 3, 4, 4, 8};
        tbl[1] = '{4, 8, 1, 2, 'h10, 2, 2, 0, 6, 3, 4, 4, 8};
        tbl[2] = '{5, 3, 5, 9, 'h20, 7, 1, 0, -1, -1, 1, 5, 3};
        tbl[3] = '{0, 14, 2, 2, 'h30, 2, 1, 0, 4, 2, 3, 2, 2};
        tbl[4] = '{13, 0, 15, 3, 'h40, 1, 1, 0, 3, 2, 3, 15, 2};
        tbl[5] = '{0, 0, 15, 15, 'hF8, 1, 4, 0, 15, 15, 16, 15, 15};
        tbl[6] = '{2, 1, 5, 7, 'h50, 2, 3, 2, 6, 3, 4, 5, 7};
        tbl[7] = '{15, 4, 15, 4, 'hFF, 3, 1, 1, -1, -1, 1, 15, 4};

        rst = 1'b1; in_valid = 1'b0; wr_ready = 1'b0; div_done = 1'b0; div_q = '0;
        v1x = '0; v1y = '0; v2x = '0; v2y = '0; base_addr = '0;
        repeat (3) tick();
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_div_start", int'(div_start), 0);
        chk("rst_wr_valid", int'(wr_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_div_num_den", int'({div_num, div_den}), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_xy", int'({wr_x, wr_y}), 0);
        chk("rst_pix_count", int'(pix_count), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_line(tbl[i].v1x, tbl[i].v1y, tbl[i].v2x, tbl[i].v2y, tbl[i].base,
                     tbl[i].q, tbl[i].lat, tbl[i].mode, xl, yl, pc, dn, dd);
            chk($sformatf("tbl%0d_div_num", i), dn, tbl[i].e_num);
            chk($sformatf("tbl%0d_div_den", i), dd, tbl[i].e_den);
            chk($sformatf("tbl%0d_pix", i), pc, tbl[i].e_pix);
            chk($sformatf("tbl%0d_last_x", i), xl, tbl[i].e_xl);
            chk($sformatf("tbl%0d_last_y", i), yl, tbl[i].e_yl);
        end

        // reset while a write is stalled in EMIT, then a late div_done
        v1x = 4'd1; v1y = 4'd2; v2x = 4'd4; v2y = 4'd8; base_addr = 8'h10;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("rs_div_start", int'(div_start), 1);
        tick();
        div_done = 1'b1; div_q = 4'd2;
        tick();
        div_done = 1'b0; wr_ready = 1'b0;
        chk("rs_emit_wr_valid", int'(wr_valid), 1);
        tick();
        chk("rs_stall_valid", int'(wr_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rs_wr_valid", int'(wr_valid), 0);
        chk("rs_in_ready", int'(in_ready), 1);
        chk("rs_busy", int'(busy), 0);
        chk("rs_wr_fields", int'({wr_addr, wr_x, wr_y}), 0);
        chk("rs_pix_count", int'(pix_count), 0);
        chk("rs_div_num_den", int'({div_num, div_den}), 0);
        div_done = 1'b1; div_q = 4'd9;
        tick();
        div_done = 1'b0;
        chk("late_done_in_ready", int'(in_ready), 1);
        chk("late_done_busy", int'(busy), 0);
        chk("late_done_wr_valid", int'(wr_valid), 0);
        tick();
        run_line(1, 2, 4, 8, 'h10, 2, 1, 0, xl, yl, pc, dn, dd);
        chk("post_rst_pix", pc, 4);
        chk("post_rst_last_y", yl, 8);

        for (int i = 0; i < 40; i++) begin
            ax = $urandom_range(0, 15); ay = $urandom_range(0, 15);
            bx = $urandom_range(0, 15); by = $urandom_range(0, 15);
            run_line(ax, ay, bx, by, $urandom_range(0, 255), $urandom_range(0, 15),
                     $urandom_range(1, 4), 1, xl, yl, pc, dn, dd);
            chk("rnd_last_x", xl, (bx < ax) ? ax : bx);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/line_raster_ctrl.md
# line_raster_ctrl

Sequencer for the GPU line-stepping datapath. It accepts one vertex pair per handshake and orders the endpoints by x. It runs the shared divider once to obtain the slope, then steps x from start to end, emitting one (address, x, y) pixel write per step toward global memory. It replaces free-running, event-triggered stepping with an explicit FSM, explicit handshakes and a defined termination.

## Interface
Parameters:
- W, 4, coordinate and slope width (unsigned, modulo 2^W arithmetic)
- AW, 8, global-memory address width

Ports (one clock; reset is synchronous and active-high):
- c  in  1  clock, all state updates on posedge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  vertex pair offered
- in_ready  out  1  high only in IDLE
- v1x, v1y, v2x, v2y  in  W each  endpoints, sampled on accept
- base_addr  in  AW  address of first pixel, sampled on accept
- div_start  out  1  one-cycle pulse requesting dy/dx
- div_num, div_den  out  W each  dy and dx, held stable from div_start until div_done
- div_done  in  1  quotient valid (earliest: cycle after div_start)
- div_q  in  W  quotient
- wr_valid  out  1  pixel write pending
- wr_ready  in  1  memory accepts write
- wr_addr  out  AW  base_addr + pixel index, modulo 2^AW
- wr_x, wr_y  out  W each  pixel coordinates
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after the last write is accepted
- pix_count  out  W+1  pixels written for the most recent line; held until the next accept

## Operation
- On accept (in_valid & in_ready), latch the endpoints. If v2x < v1x, swap the vertices so that x0 <= x1.
- dx = x1 - x0; dy = (y1 - y0) mod 2^W.
- Slope m: if dx == 0, m = 0 and the divider is not started; otherwise m = div_q.
- Pixel k (k = 0..dx): x = x0 + k; y = (y0 + k*m) mod 2^W, implemented as an accumulator y += m per step; addr = base_addr + k.
- Termination is by equality x == x1, never by <=, so x1 = 2^W-1 does not wrap or loop.
- FSM states and transitions:
  - IDLE -> DIV on accept when dx != 0.
  - IDLE -> EMIT on accept when dx == 0.
  - DIV -> WAIT (div_start high during DIV).
  - WAIT -> EMIT in the cycle after div_done; m is latched from div_q in the div_done cycle.
  - EMIT -> EMIT on wr_valid & wr_ready when x != x1 (step).
  - EMIT -> DONE on wr_valid & wr_ready when x == x1.
  - DONE -> IDLE.
- div_done outside WAIT is ignored.
- Reset values: state IDLE; in_ready 1; busy, div_start, wr_valid and done 0; div_num, div_den, wr_addr, wr_x, wr_y and pix_count 0.

## Timing
- Accept in cycle N with dx != 0: div_start high in N+1. If div_done arrives in cycle D, wr_valid rises in D+1.
- Accept in cycle N with dx == 0: wr_valid high in N+1.
- wr_valid/wr_addr/wr_x/wr_y are held stable while wr_valid & !wr_ready.
- Throughput is one pixel per cycle under continuous wr_ready.
- The last write is accepted in cycle L: done = 1 and pix_count = dx+1 in L+1; in_ready = 1 in L+2.
- in_valid while busy is not accepted and has no effect.
- rst mid-operation: IDLE in the next cycle, outputs return to their reset values, and any pending write or divider result is discarded.

## Structure
- Shared package: state encoding constants (IDLE, DIV, WAIT, EMIT, DONE) and default W/AW, for use by the divider wrapper and the global-memory write arbiter.
- One natural sub-module: line_step_acc, which holds the x/y/addr counters with load, step and last-flag outputs. The FSM stays in line_raster_ctrl. The divider is external and reached through the div_* ports.

## Test plan
- (1,2)->(4,8), base 0x10, div_q=2, wr_ready=1: div_num=6, div_den=3. Writes (0x10,1,2), (0x11,2,4), (0x12,3,6), (0x13,4,8); done pulse; pix_count=4.
- (4,8)->(1,2): the swap produces the identical write sequence to the previous case.
- (5,3)->(5,9): no div_start pulse. Single write (base,5,3); pix_count=1.
- (0,14)->(2,2), div_q=2: dy=4 after wrap. y sequence 14, 0, 2.
- (13,0)->(15,3), div_q=1: exactly 3 writes ending at x=15, then IDLE with no wrap to x=0.
- Backpressure and reset:
  - wr_ready low for 3 cycles on the second pixel: outputs stay stable and no pixel is skipped.
  - rst asserted in EMIT: next cycle IDLE, wr_valid=0, in_ready=1, and a late div_done is ignored.
